// File: rtl/reg_ctrl_pkg.sv
// rtl/reg_ctrl_pkg.sv - shared sizes and encodings for the register write-back path
package reg_ctrl_pkg;

    // Register file geometry
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // Register 0 always reads as zero and is never written
    localparam int ZERO_REG = 0;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_ALU = 0;
    localparam int GNT_MEM = 1;

    // Round-robin priority pointer: who wins when both producers request
    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } priSel_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with its priority pointer
module rr_arb2
    import reg_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       reqAlu,
    input  logic       reqMem,
    input  logic       xferDone,
    output logic [1:0] grant
);

    priSel_t priPtr;

    // A lone requester always wins; on contention the pointer picks the winner
    always_comb begin
        grant = 2'b00;
        if (reqAlu && reqMem) begin
            if (priPtr == PRI_ALU) begin
                grant[GNT_ALU] = 1'b1;
            end else begin
                grant[GNT_MEM] = 1'b1;
            end
        end else if (reqAlu) begin
            grant[GNT_ALU] = 1'b1;
        end else if (reqMem) begin
            grant[GNT_MEM] = 1'b1;
        end
    end

    // After each transfer hand priority to the requester that lost; hold otherwise
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            priPtr <= PRI_ALU;
        end else if (xferDone) begin
            priPtr <= grant[GNT_ALU] ? PRI_MEM : PRI_ALU;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - write-back arbiter, registered write port and pending-write scoreboard
module reg_wb_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int DATA_W = reg_ctrl_pkg::DATA_W,
    parameter int ADDR_W = reg_ctrl_pkg::ADDR_W,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_addr,
    input  logic [DATA_W-1:0]   alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                mem_ready,
    input  logic                issue_set,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic                flush,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   waddr,
    output logic [DATA_W-1:0]   writeValue,
    output logic [NUM_REGS-1:0] busy
);

    logic [1:0]        grant;
    logic              xferDone;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winData;

    rr_arb2 u_arb (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .reqAlu   (alu_valid),
        .reqMem   (mem_valid),
        .xferDone (xferDone),
        .grant    (grant)
    );

    // Readys are held low for as long as reset is asserted, even between edges
    assign alu_ready = grant[GNT_ALU] & RST_N;
    assign mem_ready = grant[GNT_MEM] & RST_N;
    assign xferDone  = (alu_valid & alu_ready) | (mem_valid & mem_ready);

    // Select the winning producer's address and data
    always_comb begin
        winAddr = alu_addr;
        winData = alu_data;
        if (grant[GNT_MEM]) begin
            winAddr = mem_addr;
            winData = mem_data;
        end
    end

    // One-stage write port; a transfer to R0 handshakes but never strobes the register file
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RegWrite   <= 1'b0;
            waddr      <= '0;
            writeValue <= '0;
        end else if (xferDone) begin
            RegWrite   <= (winAddr != ADDR_W'(ZERO_REG));
            waddr      <= winAddr;
            writeValue <= winData;
        end else begin
            RegWrite   <= 1'b0;
        end
    end

    // Scoreboard: flush beats a new issue, which beats the clear from a completing write
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy <= '0;
        end else begin
            busy[ZERO_REG] <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (flush) begin
                    busy[i] <= 1'b0;
                end else if (issue_set && (issue_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (RegWrite && (waddr == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed table-driven bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        alu_valid;
    logic [2:0]  alu_addr;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        issue_set;
    logic [2:0]  issue_addr;
    logic        flush;
    logic        RegWrite;
    logic [2:0]  waddr;
    logic [15:0] writeValue;
    logic [7:0]  busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] regFile [8];

    always #5 CLK = ~CLK;

    reg_wb_arbiter dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .issue_set  (issue_set),
        .issue_addr (issue_addr),
        .flush      (flush),
        .RegWrite   (RegWrite),
        .waddr      (waddr),
        .writeValue (writeValue),
        .busy       (busy)
    );

    always @(posedge CLK) begin
        if (RegWrite && waddr != 3'd0) regFile[waddr] <= writeValue;
    end

    typedef struct {
        logic        av;
        logic [2:0]  aa;
        logic [15:0] ad;
        logic        mv;
        logic [2:0]  ma;
        logic [15:0] md;
        logic        is;
        logic [2:0]  ia;
        logic        fl;
        logic        ar;
        logic        mr;
        logic        rw;
        logic        chk;
        logic [2:0]  wa;
        logic [15:0] wv;
        logic [7:0]  bz;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(
        input logic av, input logic [2:0] aa, input logic [15:0] ad,
        input logic mv, input logic [2:0] ma, input logic [15:0] md,
        input logic is, input logic [2:0] ia, input logic fl,
        input logic ar, input logic mr, input logic rw, input logic chk,
        input logic [2:0] wa, input logic [15:0] wv, input logic [7:0] bz);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.is = is; v.ia = ia; v.fl = fl; v.ar = ar; v.mr = mr; v.rw = rw;
        v.chk = chk; v.wa = wa; v.wv = wv; v.bz = bz;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        issue_set = 0; issue_addr = 0; flush = 0;
    endtask

    initial begin
        for (int r = 0; r < 8; r++) regFile[r] = 16'h0000;

        //          av aa  ad        mv ma  md        is ia  fl  ar mr rw chk wa  wv        busy
        vecs[0]  = mk(1, 3'd3, 16'h0003, 0, 3'd0, 16'h0000, 0, 3'd0, 0, 1, 0, 0, 1, 3'd0, 16'h0000, 8'h00);
        vecs[1]  = mk(0, 3'd0, 16'h0000, 1, 3'd7, 16'h0077, 0, 3'd0, 0, 0, 1, 1, 1, 3'd3, 16'h0003, 8'h00);
        vecs[2]  = mk(1, 3'd1, 16'h0011, 1, 3'd2, 16'h0022, 0, 3'd0, 0, 1, 0, 1, 1, 3'd7, 16'h0077, 8'h00);
        vecs[3]  = mk(1, 3'd1, 16'h0011, 1, 3'd2, 16'h0022, 0, 3'd0, 0, 0, 1, 1, 1, 3'd1, 16'h0011, 8'h00);
        vecs[4]  = mk(1, 3'd1, 16'h0011, 1, 3'd2, 16'h0022, 0, 3'd0, 0, 1, 0, 1, 1, 3'd2, 16'h0022, 8'h00);
        vecs[5]  = mk(1, 3'd1, 16'h0011, 1, 3'd2, 16'h0022, 0, 3'd0, 0, 0, 1, 1, 1, 3'd1, 16'h0011, 8'h00);
        vecs[6]  = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 0, 0, 0, 1, 1, 3'd2, 16'h0022, 8'h00);
        vecs[7]  = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd5, 0, 0, 0, 0, 1, 3'd2, 16'h0022, 8'h00);
        vecs[8]  = mk(0, 3'd0, 16'h0000, 1, 3'd5, 16'h0005, 0, 3'd0, 0, 0, 1, 0, 1, 3'd2, 16'h0022, 8'h20);
        vecs[9]  = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 0, 0, 0, 1, 1, 3'd5, 16'h0005, 8'h20);
        vecs[10] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd0, 0, 0, 0, 0, 1, 3'd5, 16'h0005, 8'h00);
        vecs[11] = mk(1, 3'd0, 16'hABCD, 0, 3'd0, 16'h0000, 0, 3'd0, 0, 1, 0, 0, 1, 3'd5, 16'h0005, 8'h00);
        vecs[12] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 8'h00);
        vecs[13] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd4, 0, 0, 0, 0, 0, 3'd0, 16'h0000, 8'h00);
        vecs[14] = mk(1, 3'd4, 16'h0044, 0, 3'd0, 16'h0000, 0, 3'd0, 0, 1, 0, 0, 0, 3'd0, 16'h0000, 8'h10);
        vecs[15] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd4, 0, 0, 0, 1, 1, 3'd4, 16'h0044, 8'h10);
        vecs[16] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 0, 0, 0, 0, 1, 3'd4, 16'h0044, 8'h10);
        vecs[17] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 1, 3'd6, 1, 0, 0, 0, 1, 3'd4, 16'h0044, 8'h10);
        vecs[18] = mk(0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 3'd0, 0, 0, 0, 0, 1, 3'd4, 16'h0044, 8'h00);

        // Reset held with both producers requesting
        idle_inputs();
        RST_N = 1'b0;
        alu_valid = 1; mem_valid = 1;
        #1;
        check("rst_alu_ready", alu_ready, 1'b0);
        check("rst_mem_ready", mem_ready, 1'b0);
        check("rst_RegWrite", RegWrite, 1'b0);
        check("rst_busy", busy, 8'h00);
        @(negedge CLK);
        check("rst_waddr", waddr, 3'd0);
        check("rst_writeValue", writeValue, 16'h0000);
        idle_inputs();
        RST_N = 1'b1;

        // Directed vectors: outputs sampled mid-cycle, before the edge that consumes the inputs
        for (int i = 0; i < 19; i++) begin
            @(negedge CLK);
            alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
            issue_set = vecs[i].is; issue_addr = vecs[i].ia; flush = vecs[i].fl;
            #1;
            check($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].ar);
            check($sformatf("v%0d_mem_ready", i), mem_ready, vecs[i].mr);
            check($sformatf("v%0d_RegWrite", i), RegWrite, vecs[i].rw);
            check($sformatf("v%0d_busy", i), busy, vecs[i].bz);
            if (vecs[i].chk) begin
                check($sformatf("v%0d_waddr", i), waddr, vecs[i].wa);
                check($sformatf("v%0d_writeValue", i), writeValue, vecs[i].wv);
            end
        end
        @(negedge CLK);
        idle_inputs();
        check("rf_R5", regFile[5], 16'h0005);
        check("rf_R0", regFile[0], 16'h0000);
        check("rf_R4", regFile[4], 16'h0044);
        check("rf_R7", regFile[7], 16'h0077);

        // Async reset while a write is being presented
        alu_valid = 1; alu_addr = 3'd3; alu_data = 16'h1234;
        issue_set = 1; issue_addr = 3'd3;
        @(posedge CLK);
        #1;
        idle_inputs();
        check("mid_RegWrite_pre", RegWrite, 1'b1);
        check("mid_busy_pre", busy, 8'h08);
        #1;
        RST_N = 1'b0;
        #1;
        check("mid_RegWrite_rst", RegWrite, 1'b0);
        check("mid_busy_rst", busy, 8'h00);
        check("mid_waddr_rst", waddr, 3'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        alu_valid = 1; alu_addr = 3'd2; alu_data = 16'h0202;
        mem_valid = 1; mem_addr = 3'd6; mem_data = 16'h0606;
        #1;
        check("post_rst_alu_ready", alu_ready, 1'b1);
        check("post_rst_mem_ready", mem_ready, 1'b0);
        @(negedge CLK);
        idle_inputs();
        #1;
        check("post_rst_RegWrite", RegWrite, 1'b1);
        check("post_rst_waddr", waddr, 3'd2);
        check("post_rst_writeValue", writeValue, 16'h0202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and scoreboard for the 8 x 16-bit CPU register file. It shares the register file's single write port between two producers, the ALU and the load unit, using round-robin arbitration with a valid/ready handshake. It drives the register file write strobe, address and data from a one-stage registered output. It keeps a per-register pending-write scoreboard that the issue logic uses to detect read-after-write hazards.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU has a result to write back
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU write-back accepted this cycle
- mem_valid  in  1  load unit has data to write back
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load write-back accepted this cycle
- issue_set  in  1  issue logic marks a destination register pending
- issue_addr  in  ADDR_W  register to mark pending
- flush  in  1  synchronous clear of the whole scoreboard
- RegWrite  out  1  register file write enable
- waddr  out  ADDR_W  register file write address
- writeValue  out  DATA_W  register file write data
- busy  out  NUM_REGS  scoreboard; bit i = write to register i outstanding

## Operation
- A transfer occurs when valid && ready are both high at a rising CLK.
- Ready is combinational from the valid inputs and the priority pointer. At most one ready is high per cycle.
  - Only one valid high: that requester gets ready.
  - Both valid high: the requester holding priority gets ready.
- Priority pointer (1 flop, values PRI_ALU / PRI_MEM):
  - Reset value is PRI_ALU.
  - After any transfer, the pointer moves to the requester that did not win.
  - With no transfer, the pointer holds.
- Output stage: on a transfer, register {RegWrite=1, waddr, writeValue} from the winner. With no transfer, RegWrite=0 and waddr/writeValue hold their last values.
- Register 0 is hard zero:
  - A transfer to address 0 completes its handshake, but RegWrite stays 0.
  - issue_set to address 0 is ignored, so busy[0] is always 0.
- Scoreboard update, per register i, per edge, in priority order:
  1. flush=1: busy[i] cleared, overriding everything else.
  2. issue_set && issue_addr==i (i!=0): busy[i] set. Set wins over a clear to the same register on the same edge, because it represents a new producer.
  3. RegWrite && waddr==i: busy[i] cleared.
- A write to a register whose busy bit is 0 is still performed; busy stays 0.
- No backpressure from the register file: the block sustains one write per cycle.

## Timing
- Reset (RST_N=0, asynchronous):
  - RegWrite=0, waddr=0, writeValue=0
  - busy=0, pointer=PRI_ALU
  - alu_ready=0 and mem_ready=0, forced low while RST_N=0
- Latency: transfer at the edge ending cycle N → RegWrite=1 during cycle N+1. The register file captures the data at the edge ending N+1, and the value is readable in cycle N+2.
- busy[i] clears at the same edge the register file captures the data, so busy=0 never precedes valid register contents.
- Back-to-back: transfers in consecutive cycles produce consecutive RegWrite pulses with no bubble.
- Alternation: with both valids held high, grants alternate every cycle: ALU, MEM, ALU, and so on.
- Reset mid-operation: an accepted write not yet presented (RegWrite pending) is dropped. Producers must re-issue.

## Structure
- Shared package reg_ctrl_pkg: DATA_W, ADDR_W, NUM_REGS, PRI_ALU/PRI_MEM encodings, ZERO_REG=0.
- Sub-module rr_arb2: a two-requester round-robin arbiter containing the pointer flop. It takes the two valids and a transfer-done input, and produces one-hot grant.
- Top level contains the output register stage and the scoreboard array.

## Test plan
- Reset: hold RST_N=0 with both valids high → both readys=0, RegWrite=0, busy=8'h00. Release reset, then alu_valid only, addr 3, data 16'h0003 → alu_ready=1; next cycle RegWrite=1, waddr=3, writeValue=16'h0003.
- Contention: hold both valids high for 4 cycles (ALU addr 1 data 16'h0011, MEM addr 2 data 16'h0022) → grant order ALU, MEM, ALU, MEM; RegWrite high on 4 consecutive cycles.
- Scoreboard: issue_set addr 5 → busy=8'h20. MEM writes addr 5 → busy[5] falls on the edge where RegWrite=1 is sampled. A register file instance reads 16'h0005 on the next cycle.
- Zero register: issue_set addr 0 → busy=8'h00. ALU writes addr 0 data 16'hABCD → alu_ready=1, RegWrite stays 0, and a read of R0 returns 16'h0000.
- Same-edge set/clear: busy[4]=1 and a write to 4 is in its RegWrite cycle while issue_set addr 4 is applied → busy[4] remains 1. Then assert flush together with issue_set addr 6 → busy=8'h00.
- Async reset mid-stream: assert RST_N=0 between clock edges while RegWrite=1 → RegWrite and busy go to 0 immediately without a clock edge, and pointer=PRI_ALU.
